// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: request/refill controller for a direct-mapped cache.
// After reset (and on flush) it sweeps every line to zero. It then serves one
// CPU read at a time: it looks the address up, refills from main memory on a
// miss, and returns the word.
// Optional build macro: CACHE_REFILL_STATS_EN adds the hit_count/miss_count outputs.
module cache_refill_ctrl #(
  parameter int TAG_BITS   = 20,
  parameter int INDEX_BITS = 10,
  parameter int DATA_BITS  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  input  logic [31:0]                     req_addr,
  output logic                            req_ready,
  input  logic                            flush,
  output logic                            resp_valid,
  output logic [DATA_BITS-1:0]            resp_data,
  output logic [INDEX_BITS-1:0]           lk_index,
  output logic [TAG_BITS-1:0]             lk_tag,
  input  logic                            lk_hit,
  input  logic [DATA_BITS-1:0]            lk_data,
  output logic                            mem_req,
  output logic [31:0]                     mem_addr,
  input  logic                            mem_ack,
  input  logic [DATA_BITS-1:0]            mem_rdata,
  output logic                            cache_we,
  output logic [INDEX_BITS-1:0]           cache_windex,
  output logic [TAG_BITS+DATA_BITS:0]     cache_wline
`ifdef CACHE_REFILL_STATS_EN
  ,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count
`endif
);

  localparam int WORD_ADDR_BITS = TAG_BITS + INDEX_BITS;

  localparam logic [2:0] INIT    = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] LOOKUP  = 3'd2;
  localparam logic [2:0] MEM_REQ = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam logic [INDEX_BITS-1:0] IDX_ONE  = 1;
  localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;

  logic [2:0]                state;
  logic [INDEX_BITS-1:0]     sweep_count;
  logic [WORD_ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0]      data_q;
  logic                      unused_offset;

  // The byte offset never matters: whole words are always returned.
  assign unused_offset = ^req_addr[1:0];

  assign lk_index   = addr_q[INDEX_BITS-1:0];
  assign lk_tag     = addr_q[WORD_ADDR_BITS-1:INDEX_BITS];
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_req    = (state == MEM_REQ);
  assign mem_addr   = {addr_q, 2'b00};
  assign cache_we   = (state == INIT) || (state == FILL);

  // The sweep writes all-zero lines. A fill writes a valid line for the latched address.
  always_comb begin
    cache_windex = addr_q[INDEX_BITS-1:0];
    cache_wline  = {1'b1, addr_q[WORD_ADDR_BITS-1:INDEX_BITS], data_q};
    if (state == INIT) begin
      cache_windex = sweep_count;
      cache_wline  = '0;
    end
  end

  // Main control FSM. Reset abandons any in-flight miss, so no partial fill is ever written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      sweep_count <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data   <= '0;
    end else begin
      case (state)
        INIT: begin
          sweep_count <= sweep_count + IDX_ONE;
          if (sweep_count == IDX_LAST) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (flush) begin
            sweep_count <= '0;
            state       <= INIT;
          end else if (req_valid) begin
            addr_q <= req_addr[WORD_ADDR_BITS+1:2];
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lk_hit) begin
            data_q    <= lk_data;
            resp_data <= lk_data;
            state     <= RESP;
          end else begin
            state <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            data_q <= mem_rdata;
            state  <= FILL;
          end
        end
        FILL: begin
          resp_data <= data_q;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          sweep_count <= '0;
          state       <= INIT;
        end
      endcase
    end
  end

`ifdef CACHE_REFILL_STATS_EN
  // Hit/miss statistics, counted when the lookup completes. A flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (lk_hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  // This build has no statistics counters.
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: self-checking bench for cache_refill_ctrl.
// The bench models the lookup-stage array, which the DUT fills through cache_we.
// It also keeps a separate reference of the expected cache contents, built from
// the request/flush/reset rules, and uses it to predict hits, data and refill writes.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [9:0]  lk_index;
  logic [19:0] lk_tag;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        cache_we;
  logic [9:0]  cache_windex;
  logic [52:0] cache_wline;
`ifdef CACHE_REFILL_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  // Lookup-stage array, written by the DUT or by a bench preload.
  logic [52:0] cache_arr [1024];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [52:0] pre_line;

  // Reference model of the expected cache contents and statistics.
  logic        ref_valid [1024];
  logic [19:0] ref_tag   [1024];
  logic [31:0] ref_data  [1024];
  int          ref_hits;
  int          ref_misses;

  typedef struct {
    logic [31:0] addr;
    int          delay;
    logic [31:0] rdata;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid),
    .resp_data(resp_data), .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_hit(lk_hit), .lk_data(lk_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cache_we(cache_we),
    .cache_windex(cache_windex), .cache_wline(cache_wline)
`ifdef CACHE_REFILL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // Cache array storage: DUT writes take priority over bench preloads.
  always @(posedge clk) begin
    if (cache_we) cache_arr[cache_windex] <= cache_wline;
    else if (pre_en) cache_arr[pre_idx] <= pre_line;
  end

  assign lk_hit  = cache_arr[lk_index][52] && (cache_arr[lk_index][51:32] == lk_tag);
  assign lk_data = cache_arr[lk_index][31:0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic refClear;
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic checkSweep(input string name);
    int good;
    good = 0;
    for (int c = 0; c < 1024; c++) begin
      if (cache_we === 1'b1 && cache_windex === c[9:0] && cache_wline === 53'd0 &&
          req_ready === 1'b0 && resp_valid === 1'b0 && mem_req === 1'b0)
        good++;
      tick();
    end
    checkOutput({name, "_sweep_cycles"}, good, 1024);
    checkOutput({name, "_ready_after"}, {cache_we, req_ready}, 2'b01);
  endtask

  task automatic applyReset(input string name);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    tick();
    rst = 1'b0;
    refClear();
    ref_hits = 0;
    ref_misses = 0;
    checkOutput({name, "_reset_ctrl"}, {req_ready, resp_valid, mem_req}, 3'b000);
    checkOutput({name, "_reset_data"}, {resp_data, mem_addr}, 64'd0);
    checkSweep(name);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input int delay, input logic [31:0] rdata,
                               input logic exp_hit, input logic [31:0] exp_data, input string name);
    int stay;
    checkOutput({name, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    checkOutput({name, "_lookup_ctrl"}, {req_ready, resp_valid, mem_req, cache_we}, 4'b0000);
    checkOutput({name, "_lookup_addr"}, {lk_tag, lk_index}, addr[31:2]);
    tick();
    mem_ack = 1'b0;
    if (exp_hit) begin
      ref_hits++;
      checkOutput({name, "_hit_resp"}, {resp_valid, mem_req, cache_we}, 3'b100);
      checkOutput({name, "_hit_data"}, resp_data, exp_data);
      tick();
    end else begin
      ref_misses++;
      checkOutput({name, "_mem_req"}, {mem_req, mem_addr}, {1'b1, addr[31:2], 2'b00});
      stay = 0;
      for (int i = 0; i < delay; i++) begin
        tick();
        if (mem_req === 1'b1 && resp_valid === 1'b0 && cache_we === 1'b0) stay++;
      end
      checkOutput({name, "_mem_wait"}, stay, delay);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      checkOutput({name, "_fill"}, {cache_we, cache_windex, cache_wline},
                  {1'b1, addr[11:2], 1'b1, addr[31:12], rdata});
      checkOutput({name, "_fill_ctrl"}, {resp_valid, mem_req}, 2'b00);
      ref_valid[addr[11:2]] = 1'b1;
      ref_tag[addr[11:2]]   = addr[31:12];
      ref_data[addr[11:2]]  = rdata;
      tick();
      checkOutput({name, "_miss_resp"}, {resp_valid, cache_we}, 2'b10);
      checkOutput({name, "_miss_data"}, resp_data, exp_data);
      tick();
    end
    checkOutput({name, "_hold"}, {resp_valid, req_ready, resp_data}, {2'b01, exp_data});
  endtask

  task automatic doFlush(input logic with_req);
    flush     = 1'b1;
    req_valid = with_req;
    req_addr  = $urandom;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    refClear();
    checkSweep("flush");
  endtask

  task automatic randomRequest(input int n);
    logic [19:0] tag;
    logic [9:0]  idx;
    logic [1:0]  off;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        hit;
    tag   = 20'($urandom_range(0, 3));
    idx   = 10'($urandom_range(0, 7));
    off   = 2'($urandom_range(0, 3));
    addr  = {tag, idx, off};
    rdata = $urandom;
    hit   = ref_valid[idx] && (ref_tag[idx] == tag);
    applyStimulus(addr, int'($urandom_range(0, 4)), rdata, hit, hit ? ref_data[idx] : rdata,
                  $sformatf("rnd%0d", n));
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; pre_en = 1'b0; pre_idx = '0; pre_line = '0;
    vecs[0] = '{32'hABCDE014, 0, 32'h0,        1'b1, 32'h12345678};
    vecs[1] = '{32'hABCDE017, 0, 32'h0,        1'b1, 32'h12345678};
    vecs[2] = '{32'h00001008, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{32'h00001008, 0, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[4] = '{32'h0000100A, 0, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[5] = '{32'h12345014, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    vecs[6] = '{32'hABCDE014, 1, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE};
    vecs[7] = '{32'hABCDE014, 0, 32'h0,        1'b1, 32'h0BADC0DE};
    repeat (2) tick();

    applyReset("rst");

    pre_en = 1'b1; pre_idx = 10'd5; pre_line = {1'b1, 20'hABCDE, 32'h12345678};
    tick();
    pre_en = 1'b0;
    ref_valid[5] = 1'b1; ref_tag[5] = 20'hABCDE; ref_data[5] = 32'h12345678;

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].addr, vecs[i].delay, vecs[i].rdata, vecs[i].exp_hit,
                    vecs[i].exp_data, $sformatf("vec%0d", i));

    doFlush(1'b1);
    applyStimulus(32'h00001008, 2, 32'h5555AAAA, 1'b0, 32'h5555AAAA, "after_flush");

    req_valid = 1'b1; req_addr = 32'h00002010;
    tick();
    req_valid = 1'b0;
    tick();
    checkOutput("rst_memreq_pre", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    checkOutput("rst_memreq_drop", {mem_req, resp_valid, req_ready}, 3'b000);
    refClear();
    ref_hits = 0;
    ref_misses = 0;
    checkSweep("rst_memreq");
    mem_ack = 1'b0;
    applyStimulus(32'h00002010, 0, 32'h13579BDF, 1'b0, 32'h13579BDF, "after_rst_memreq");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 39) == 0) doFlush(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        checkOutput($sformatf("gap%0d", n), {req_ready, resp_valid, mem_req}, 3'b100);
      end
      randomRequest(n);
    end

`ifdef CACHE_REFILL_STATS_EN
    checkOutput("stats_rnd_hits", hit_count, ref_hits);
    checkOutput("stats_rnd_misses", miss_count, ref_misses);
    applyReset("stats_rst");
    checkOutput("stats_clear", {hit_count, miss_count}, 64'd0);
    applyStimulus(32'h00003000, 1, 32'hA0A0A0A0, 1'b0, 32'hA0A0A0A0, "st_m1");
    applyStimulus(32'h00003000, 0, 32'h0,        1'b1, 32'hA0A0A0A0, "st_h1");
    applyStimulus(32'h00003000, 0, 32'h0,        1'b1, 32'hA0A0A0A0, "st_h2");
    applyStimulus(32'h00004004, 0, 32'hB1B1B1B1, 1'b0, 32'hB1B1B1B1, "st_m2");
    applyStimulus(32'h00004004, 0, 32'h0,        1'b1, 32'hB1B1B1B1, "st_h3");
    checkOutput("stats_hits", hit_count, 3);
    checkOutput("stats_misses", miss_count, 2);
    applyReset("stats_rst2");
    checkOutput("stats_clear2", {hit_count, miss_count}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
